alt_vipitc131_common_trigger_arbiter: RTL and testbench

Single-clock round-robin scheduler that shares one clock-crossing trigger channel between up to NUM_REQ requesters. Sits in the source clock domain, in front of the common trigger synchroniser. Issues one single-cycle trigger per granted request and waits for the returned acknowledge. Enforces a minimum holdoff between triggers so the toggle-based crossing never merges two events.

---
 rtl/alt_vipitc131_common_trigger_arbiter_pkg.sv | 17 +
 rtl/alt_vipitc131_common_rr_arbiter.sv | 30 +++
 rtl/alt_vipitc131_common_trigger_arbiter.sv | 148 ++++++++++++++
 tb/tb_alt_vipitc131_common_trigger_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alt_vipitc131_common_trigger_arbiter_pkg.sv
// Shared types and sizing helpers for the common trigger arbiter.
package alt_vipitc131_common_trigger_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    HOLDOFF  = 2'd2
  } arb_state_e;

  // Counter width able to hold the larger of the holdoff and timeout limits.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m == 0) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/alt_vipitc131_common_rr_arbiter.sv
// Combinational round-robin pick: searches upward from last_grant+1, wrapping.
module alt_vipitc131_common_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] winner_oh_c,
  output logic [IDX_W-1:0]   winner_idx_c,
  output logic               valid_c
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    winner_oh_c  = '0;
    winner_idx_c = '0;
    valid_c      = 1'b0;
    cand         = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(last_grant) + i) % NUM_REQ);
      if (!valid_c && req[cand]) begin
        valid_c           = 1'b1;
        winner_oh_c[cand] = 1'b1;
        winner_idx_c      = cand;
      end
    end
  end

endmodule

// File: rtl/alt_vipitc131_common_trigger_arbiter.sv
// Round-robin scheduler sharing one trigger crossing between NUM_REQ requesters.
// Optional WAIT_ACK timeout enabled by ALT_VIPITC131_TRIG_ARB_TIMEOUT_EN.
module alt_vipitc131_common_trigger_arbiter
  import alt_vipitc131_common_trigger_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned HOLDOFF_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic               trigger_out,
  input  logic               ack_in,
  output logic               busy,
  output logic               timeout_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = cnt_width(HOLDOFF_CYCLES, TIMEOUT_CYCLES);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               trig_q, trig_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               finish_c;
`ifdef ALT_VIPITC131_TRIG_ARB_TIMEOUT_EN
  logic               timeout_q, timeout_d;
`endif

  logic [NUM_REQ-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               win_valid;

  alt_vipitc131_common_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req          (req),
    .last_grant   (last_q),
    .winner_oh_c  (win_oh),
    .winner_idx_c (win_idx),
    .valid_c      (win_valid)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    done_d   = '0;
    trig_d   = 1'b0;
    finish_c = 1'b0;
`ifdef ALT_VIPITC131_TRIG_ARB_TIMEOUT_EN
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          grant_d = win_oh;
          gidx_d  = win_idx;
          trig_d  = 1'b1;
          cnt_d   = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // An ack arriving on the limit cycle takes priority over the timeout.
        if (ack_in) begin
          finish_c = 1'b1;
        end
`ifdef ALT_VIPITC131_TRIG_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          finish_c  = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
        if (finish_c) begin
          done_d  = grant_q;
          grant_d = '0;
          last_d  = gidx_q;
          if (HOLDOFF_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = HOLDOFF;
            cnt_d   = CNT_W'(HOLDOFF_CYCLES - 1);
          end
        end
      end
      HOLDOFF: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      done_q  <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef ALT_VIPITC131_TRIG_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      done_q  <= done_d;
      trig_q  <= trig_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
`ifdef ALT_VIPITC131_TRIG_ARB_TIMEOUT_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign trigger_out = trig_q;
  assign busy        = busy_q;
`ifdef ALT_VIPITC131_TRIG_ARB_TIMEOUT_EN
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_alt_vipitc131_common_trigger_arbiter.sv
// Self-checking bench for alt_vipitc131_common_trigger_arbiter (transaction-level model).
module tb_alt_vipitc131_common_trigger_arbiter;

  localparam int N  = 4;
  localparam int H  = 4;
  localparam int TO = 8;
`ifdef ALT_VIPITC131_TRIG_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] req = '0;
  logic         ack_in = 1'b0;
  logic [N-1:0] grant, done;
  logic         trigger_out, busy, timeout_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  alt_vipitc131_common_trigger_arbiter #(
    .NUM_REQ        (4),
    .HOLDOFF_CYCLES (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .done        (done),
    .trigger_out (trigger_out),
    .ack_in      (ack_in),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Transaction view: who owns the channel, how long it has waited, holdoff remaining.
  typedef struct {
    bit           active;
    int           owner;
    int           last;
    int           waited;
    int           hold;
    logic [N-1:0] done;
    bit           trig;
    bit           tmo;
  } mst_t;

  function automatic mst_t mreset();
    mst_t s;
    s.active = 1'b0; s.owner = 0; s.last = N - 1; s.waited = 0; s.hold = 0;
    s.done = '0; s.trig = 1'b0; s.tmo = 1'b0;
    return s;
  endfunction

  function automatic mst_t mstep(input mst_t s, input logic [N-1:0] r, input logic a);
    mst_t n;
    bit   found;
    n = s;
    found = 1'b0;
    n.done = '0; n.trig = 1'b0; n.tmo = 1'b0;
    if (s.active) begin
      if (a || (TMO_EN && s.waited == TO)) begin
        n.done[s.owner] = 1'b1;
        n.tmo    = !a;
        n.last   = s.owner;
        n.active = 1'b0;
        n.hold   = H;
      end else begin
        n.waited = s.waited + 1;
      end
    end else if (s.hold > 0) begin
      n.hold = s.hold - 1;
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (!found && r[(s.last + k) % N]) begin
          found    = 1'b1;
          n.active = 1'b1;
          n.owner  = (s.last + k) % N;
          n.waited = 0;
          n.trig   = 1'b1;
        end
      end
    end
    return n;
  endfunction

  mst_t m;
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) m <= mreset();
    else        m <= mstep(m, req, ack_in);
  end

  logic [N-1:0] exp_grant;
  always_comb exp_grant = m.active ? N'(1 << m.owner) : '0;

  always @(negedge clock) begin
    check("grant",       32'(grant),       32'(exp_grant));
    check("done",        32'(done),        32'(m.done));
    check("trigger_out", 32'(trigger_out), 32'(m.trig));
    check("busy",        32'(busy),        32'(m.active || m.hold > 0));
    check("timeout_err", 32'(timeout_err), 32'(m.tmo));
  end

  // ack policy: 0 manual, 1 fixed delay after each trigger, 2 random
  int   ack_mode  = 0;
  int   ack_delay = 0;
  int   ack_cd    = -1;
  logic ack_man   = 1'b0;

  task automatic cycle();
    @(negedge clock);
    case (ack_mode)
      0: ack_in = ack_man;
      1: begin
        if (m.trig) ack_cd = ack_delay;
        else if (ack_cd >= 0) ack_cd--;
        ack_in = (ack_cd == 0);
      end
      default: ack_in = ($urandom_range(0, 3) == 0);
    endcase
  endtask

  task automatic do_reset();
    req = '0; ack_man = 1'b0; ack_mode = 0; ack_cd = -1;
    rst_n = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;
  endtask

  // Hold req, collect trigger pulses: grants cycle through nact ascending bits.
  task automatic run_rr(input string nm, input int want_n, input int nact, input int gap);
    int ntrig;
    int last_t;
    ntrig = 0;
    last_t = 0;
    for (int c = 0; c < 80 && ntrig < want_n; c++) begin
      cycle();
      if (trigger_out === 1'b1) begin
        check({nm, "_grant"}, 32'(grant), 32'(1 << (ntrig % nact)));
        if (ntrig > 0) check({nm, "_spacing"}, 32'(c - last_t), 32'(gap));
        last_t = c;
        ntrig++;
      end
    end
    check({nm, "_count"}, 32'(ntrig), 32'(want_n));
  endtask

  initial begin
    int ntr;
    int seen;
    #1 do_reset();

    repeat (10) begin
      cycle();
      check("idle_busy",  32'(busy),  32'd0);
      check("idle_grant", 32'(grant), 32'd0);
    end
    req = 4'b0001;
    cycle();
    check("first_trig",  32'(trigger_out), 32'd1);
    check("first_grant", 32'(grant),       32'h1);
    cycle(); cycle();
    ack_man = 1'b1; cycle();
    ack_man = 1'b0; cycle();
    check("first_done", 32'(done), 32'h1);
    req = '0;
    repeat (8) cycle();

    do_reset();
    ack_mode = 1; ack_delay = 1; req = 4'b1111;
    run_rr("rr4", 5, 4, 2 + 1 + H);

    do_reset();
    ack_mode = 1; ack_delay = 0; req = 4'b0011;
    run_rr("minspace", 2, 2, 2 + H);

    do_reset();
    req = 4'b0100;
    cycle();
    check("drop_trig",  32'(trigger_out), 32'd1);
    check("drop_grant", 32'(grant),       32'h4);
    cycle();
    req = '0;
    ack_man = 1'b1; cycle();
    ack_man = 1'b0; cycle();
    check("drop_done", 32'(done), 32'h4);
    ntr = 0;
    repeat (12) begin
      cycle();
      if (trigger_out === 1'b1) ntr++;
    end
    check("drop_no_retrig", 32'(ntr), 32'd0);

`ifdef ALT_VIPITC131_TRIG_ARB_TIMEOUT_EN
    do_reset();
    req = 4'b0011;
    cycle();
    check("tmo_trig", 32'(trigger_out), 32'd1);
    seen = 0;
    for (int c = 1; c <= 20 && seen == 0; c++) begin
      cycle();
      if (timeout_err === 1'b1) begin
        seen = c;
        check("tmo_done", 32'(done), 32'h1);
      end
    end
    check("tmo_latency", 32'(seen), 32'd9);
    req = 4'b0010;
    seen = 0;
    for (int c = 1; c <= 20 && seen == 0; c++) begin
      cycle();
      if (trigger_out === 1'b1) begin
        seen = c;
        check("tmo_next_grant", 32'(grant), 32'h2);
      end
    end
    check("tmo_next_latency", 32'(seen), 32'(H + 1));
`endif

    do_reset();
    req = 4'b0001;
    cycle(); cycle();
    #2 rst_n = 1'b0;
    #1;
    check("rst_grant", 32'(grant),       32'd0);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_trig",  32'(trigger_out), 32'd0);
    check("rst_done",  32'(done),        32'd0);
    check("rst_tmo",   32'(timeout_err), 32'd0);
    req = '0;
    cycle(); cycle();
    rst_n = 1'b1;
    req = 4'b1000;
    cycle();
    check("post_rst_grant", 32'(grant),       32'h8);
    check("post_rst_trig",  32'(trigger_out), 32'd1);

    do_reset();
    ack_mode = 2;
    repeat (3000) begin
      cycle();
      if ($urandom_range(0, 7) == 0) req[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 63) == 0) req = N'($urandom_range(0, 15));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
